// File: rtl/pixel_scan_scheduler_pkg.sv
// Shared types and constants for the pixel scan scheduler.
// Raster geometry defaults and coordinate widths.
package pixel_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam int H_ACTIVE_DEF     = 1024;
  localparam int V_ACTIVE_DEF     = 768;
  localparam int MAX_INFLIGHT_DEF = 32;
  localparam int HCOUNT_W         = 11;
  localparam int VCOUNT_W         = 10;

endpackage

// File: rtl/pixel_scan_scheduler_if.sv
// Paired hcount/vcount AXI-stream bundle.
// master drives coordinates, slave returns tready.
interface pixel_scan_if;
  import pixel_scan_pkg::*;

  logic [HCOUNT_W-1:0] hcount_axis_tdata;
  logic                hcount_axis_tvalid;
  logic                hcount_axis_tready;
  logic [VCOUNT_W-1:0] vcount_axis_tdata;
  logic                vcount_axis_tvalid;
  logic                vcount_axis_tready;

  modport master (
    output hcount_axis_tdata,
    output hcount_axis_tvalid,
    input  hcount_axis_tready,
    output vcount_axis_tdata,
    output vcount_axis_tvalid,
    input  vcount_axis_tready
  );

  modport slave (
    input  hcount_axis_tdata,
    input  hcount_axis_tvalid,
    output hcount_axis_tready,
    input  vcount_axis_tdata,
    input  vcount_axis_tvalid,
    output vcount_axis_tready
  );

endinterface

// File: rtl/pixel_scan_scheduler_raster_counter.sv
// Row-major h/v raster position register.
// last flags the final pixel of the frame.
module pixel_raster_counter
  import pixel_scan_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                advance,
  output logic [HCOUNT_W-1:0] h,
  output logic [VCOUNT_W-1:0] v,
  output logic                last
);

  localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(H_ACTIVE - 1);
  localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(V_ACTIVE - 1);

  logic h_end;
  logic v_end;

  assign h_end = (h == H_LAST);
  assign v_end = (v == V_LAST);
  assign last  = h_end && v_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (clear) begin
      h <= '0;
      v <= '0;
    end else if (advance) begin
      if (h_end) begin
        h <= '0;
        v <= v_end ? '0 : v + VCOUNT_W'(1);
      end else begin
        h <= h + HCOUNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_scan_scheduler.sv
// Frame pixel sequencer with credit-limited ray issue.
// Issues row-major h/v beat pairs and reports frame completion.
module pixel_scan_scheduler
  import pixel_scan_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic              abort,
  input  logic              ray_done,
  pixel_scan_if.master      axis,
  output logic              busy,
  output logic              frame_done,
  output logic [CW-1:0]     inflight,
  output logic              credit_err
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_INFLIGHT);

  state_t        state, state_n;
  logic          h_valid, h_valid_n;
  logic          v_valid, v_valid_n;
  logic          h_sent, h_sent_n;
  logic          v_sent, v_sent_n;
  logic          abort_q, abort_q_n;
  logic          busy_n, frame_done_n, credit_err_n;
  logic [CW-1:0] inflight_n;

  logic                h_hs, v_hs, issue, ret;
  logic                credit_ok, stop;
  logic                clear, advance, last;
  logic [HCOUNT_W-1:0] h;
  logic [VCOUNT_W-1:0] v;

  pixel_raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_raster (
    .clk     (aclk),
    .rst_n   (aresetn),
    .clear   (clear),
    .advance (advance),
    .h       (h),
    .v       (v),
    .last    (last)
  );

  assign axis.hcount_axis_tdata  = h;
  assign axis.vcount_axis_tdata  = v;
  assign axis.hcount_axis_tvalid = h_valid;
  assign axis.vcount_axis_tvalid = v_valid;

  assign h_hs  = h_valid && axis.hcount_axis_tready;
  assign v_hs  = v_valid && axis.vcount_axis_tready;
  // a pixel counts once both halves of the pair have handshaken
  assign issue = (state == ISSUE) && (h_hs || h_sent) && (v_hs || v_sent);
  assign ret   = ray_done && (inflight != '0);
  assign stop  = abort || abort_q;

  always_comb begin
    unique case ({issue, ret})
      2'b10:   inflight_n = inflight + CW'(1);
      2'b01:   inflight_n = inflight - CW'(1);
      default: inflight_n = inflight;
    endcase
  end

  assign credit_ok = (inflight_n < MAX_C);

  always_comb begin
    state_n      = state;
    h_valid_n    = h_valid;
    v_valid_n    = v_valid;
    h_sent_n     = h_sent;
    v_sent_n     = v_sent;
    abort_q_n    = abort_q;
    frame_done_n = 1'b0;
    credit_err_n = credit_err || (ray_done && inflight == '0);
    clear        = 1'b0;
    advance      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n      = ISSUE;
          clear        = 1'b1;
          h_valid_n    = credit_ok;
          v_valid_n    = credit_ok;
          h_sent_n     = 1'b0;
          v_sent_n     = 1'b0;
          abort_q_n    = 1'b0;
          credit_err_n = ray_done && inflight == '0;
        end
      end
      ISSUE: begin
        if (issue) begin
          advance   = 1'b1;
          h_sent_n  = 1'b0;
          v_sent_n  = 1'b0;
          abort_q_n = 1'b0;
          if (last || stop) begin
            state_n   = DRAIN;
            h_valid_n = 1'b0;
            v_valid_n = 1'b0;
          end else begin
            h_valid_n = credit_ok;
            v_valid_n = credit_ok;
          end
        end else if (!h_valid && !v_valid) begin
          if (stop) begin
            state_n = DRAIN;
          end else begin
            h_valid_n = credit_ok;
            v_valid_n = credit_ok;
          end
        end else begin
          if (h_hs) begin
            h_valid_n = 1'b0;
            h_sent_n  = 1'b1;
          end
          if (v_hs) begin
            v_valid_n = 1'b0;
            v_sent_n  = 1'b1;
          end
          abort_q_n = stop;
        end
      end
      DRAIN: begin
        h_valid_n = 1'b0;
        v_valid_n = 1'b0;
        if (inflight_n == '0) begin
          state_n      = IDLE;
          frame_done_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      h_valid    <= 1'b0;
      v_valid    <= 1'b0;
      h_sent     <= 1'b0;
      v_sent     <= 1'b0;
      abort_q    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      inflight   <= '0;
      credit_err <= 1'b0;
    end else begin
      state      <= state_n;
      h_valid    <= h_valid_n;
      v_valid    <= v_valid_n;
      h_sent     <= h_sent_n;
      v_sent     <= v_sent_n;
      abort_q    <= abort_q_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
      inflight   <= inflight_n;
      credit_err <= credit_err_n;
    end
  end

endmodule

// File: tb/tb_pixel_scan_scheduler.sv
// Self-checking bench for pixel_scan_scheduler.
// 4x2 raster, four credits, scoreboarded h/v beats.
module tb_pixel_scan_scheduler;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       rd_auto = 1'b0;
  logic       rd_man = 1'b0;
  logic       ray_done;
  logic       busy;
  logic       frame_done;
  logic [2:0] inflight;
  logic       credit_err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int nh, nv, niss, n_fd, fd_cyc, last_rd;
  bit auto_en = 0;
  bit fd_ok;
  int hq[$];
  int vq[$];
  int done_q[$];
  int iss_cyc[$];

  assign ray_done = rd_auto | rd_man;

  pixel_scan_if axis ();

  pixel_scan_scheduler #(
    .H_ACTIVE     (4),
    .V_ACTIVE     (2),
    .MAX_INFLIGHT (4)
  ) dut (
    .aclk       (clk),
    .aresetn    (aresetn),
    .start      (start),
    .abort      (abort),
    .ray_done   (ray_done),
    .axis       (axis),
    .busy       (busy),
    .frame_done (frame_done),
    .inflight   (inflight),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  // cycle counter and delayed ray retirement
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    while (done_q.size() > 0 && done_q[0] < cyc)
      void'(done_q.pop_front());
    rd_auto = 1'b0;
    if (auto_en && done_q.size() > 0 && done_q[0] == cyc) begin
      rd_auto = 1'b1;
      void'(done_q.pop_front());
    end
  end

  // scoreboard: compare each accepted beat with the expected queue
  always @(negedge clk) begin
    if (aresetn) begin
      int e;
      int m;
      if (axis.hcount_axis_tvalid && axis.hcount_axis_tready) begin
        nh++;
        n_chk++;
        if (hq.size() == 0) begin
          n_fail++;
          $display("FAIL h_beat unexpected got %0d exp none",
                   axis.hcount_axis_tdata);
        end else begin
          e = hq.pop_front();
          if (int'(axis.hcount_axis_tdata) !== e) begin
            n_fail++;
            $display("FAIL h_beat got %0d exp %0d",
                     axis.hcount_axis_tdata, e);
          end
        end
      end
      if (axis.vcount_axis_tvalid && axis.vcount_axis_tready) begin
        nv++;
        n_chk++;
        if (vq.size() == 0) begin
          n_fail++;
          $display("FAIL v_beat unexpected got %0d exp none",
                   axis.vcount_axis_tdata);
        end else begin
          e = vq.pop_front();
          if (int'(axis.vcount_axis_tdata) !== e) begin
            n_fail++;
            $display("FAIL v_beat got %0d exp %0d",
                     axis.vcount_axis_tdata, e);
          end
        end
      end
      m = (nh < nv) ? nh : nv;
      if (m > niss) begin
        niss++;
        iss_cyc.push_back(cyc);
        if (auto_en) done_q.push_back(cyc + 3);
      end
      if (ray_done) last_rd = cyc;
      if (frame_done) begin
        n_fd++;
        fd_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) begin
      hq.push_back(i % 4);
      vq.push_back(i / 4);
    end
  endtask

  task automatic clear_sb();
    hq.delete();
    vq.delete();
    done_q.delete();
    iss_cyc.delete();
    nh = 0;
    nv = 0;
    niss = 0;
    n_fd = 0;
    fd_cyc = -1;
    last_rd = -1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    rd_man = 1'b0;
    auto_en = 0;
    axis.hcount_axis_tready = 1'b1;
    axis.vcount_axis_tready = 1'b1;
    clear_sb();
    step();
    step();
    aresetn = 1'b1;
    step();
  endtask

  task automatic do_start(output int s);
    s = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_fd(input int lim);
    int n = 0;
    while (n_fd == 0 && n < lim) begin
      step();
      n++;
    end
    fd_ok = (n_fd != 0);
  endtask

  task automatic test_reset();
    logic [29:0] o;
    aresetn = 1'b0;
    axis.hcount_axis_tready = 1'b1;
    axis.vcount_axis_tready = 1'b1;
    clear_sb();
    step();
    step();
    o = {busy, frame_done, inflight, credit_err,
         axis.hcount_axis_tvalid, axis.vcount_axis_tvalid,
         axis.hcount_axis_tdata, axis.vcount_axis_tdata};
    n_chk++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h exp 0", o);
    end
    aresetn = 1'b1;
    step();
    step();
    n_chk++;
    if ({busy, axis.hcount_axis_tvalid, frame_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset got %b exp 000",
               {busy, axis.hcount_axis_tvalid, frame_done});
    end
  endtask

  task automatic test_frame();
    int s;
    do_reset();
    auto_en = 1;
    push_frame(8);
    do_start(s);
    n_chk++;
    if ({busy, axis.hcount_axis_tvalid, axis.vcount_axis_tvalid}
        !== 3'b111) begin
      n_fail++;
      $display("FAIL start_latency got %b exp 111",
               {busy, axis.hcount_axis_tvalid, axis.vcount_axis_tvalid});
    end
    wait_fd(100);
    n_chk++;
    if (!fd_ok) begin
      n_fail++;
      $display("FAIL frame_timeout got 0 exp 1");
    end
    repeat (3) step();
    n_chk++;
    if (niss !== 8) begin
      n_fail++;
      $display("FAIL frame_issues got %0d exp 8", niss);
    end
    if (niss == 8) begin
      n_chk++;
      if (iss_cyc[0] !== s + 1 || iss_cyc[7] !== s + 8) begin
        n_fail++;
        $display("FAIL frame_rate got %0d..%0d exp %0d..%0d",
                 iss_cyc[0], iss_cyc[7], s + 1, s + 8);
      end
    end
    n_chk++;
    if (n_fd !== 1 || fd_cyc !== last_rd + 1) begin
      n_fail++;
      $display("FAIL frame_done_timing got n=%0d c=%0d exp n=1 c=%0d",
               n_fd, fd_cyc, last_rd + 1);
    end
    n_chk++;
    if (hq.size() + vq.size() !== 0 || busy !== 1'b0 || inflight !== 3'd0) begin
      n_fail++;
      $display("FAIL frame_end got q=%0d busy=%b infl=%0d exp 0 0 0",
               hq.size() + vq.size(), busy, inflight);
    end
  endtask

  task automatic test_credit();
    int s;
    do_reset();
    push_frame(8);
    do_start(s);
    repeat (6) step();
    n_chk++;
    if (niss !== 4 || axis.hcount_axis_tvalid !== 1'b0 ||
        axis.vcount_axis_tvalid !== 1'b0 || inflight !== 3'd4) begin
      n_fail++;
      $display("FAIL credit_stall got n=%0d hv=%b%b infl=%0d exp 4 00 4",
               niss, axis.hcount_axis_tvalid, axis.vcount_axis_tvalid, inflight);
    end
    rd_man = 1'b1;
    step();
    rd_man = 1'b0;
    n_chk++;
    if (axis.hcount_axis_tvalid !== 1'b1 || axis.vcount_axis_tvalid !== 1'b1 ||
        inflight !== 3'd3) begin
      n_fail++;
      $display("FAIL credit_return got hv=%b%b infl=%0d exp 11 3",
               axis.hcount_axis_tvalid, axis.vcount_axis_tvalid, inflight);
    end
    step();
    n_chk++;
    if (niss !== 5 || inflight !== 3'd4 || axis.hcount_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_refill got n=%0d infl=%0d hv=%b exp 5 4 0",
               niss, inflight, axis.hcount_axis_tvalid);
    end
  endtask

  task automatic test_split();
    int s;
    do_reset();
    push_frame(2);
    axis.vcount_axis_tready = 1'b0;
    do_start(s);
    step();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (axis.hcount_axis_tvalid !== 1'b0 || axis.vcount_axis_tvalid !== 1'b1 ||
          axis.vcount_axis_tdata !== 10'd0 || inflight !== 3'd0) begin
        n_fail++;
        $display("FAIL split_hold got hv=%b%b vd=%0d infl=%0d exp 01 0 0",
                 axis.hcount_axis_tvalid, axis.vcount_axis_tvalid,
                 axis.vcount_axis_tdata, inflight);
      end
      step();
    end
    axis.vcount_axis_tready = 1'b1;
    n_chk++;
    if (nh !== 1 || nv !== 0) begin
      n_fail++;
      $display("FAIL split_counts got h=%0d v=%0d exp 1 0", nh, nv);
    end
    step();
    n_chk++;
    if (inflight !== 3'd1 || axis.hcount_axis_tvalid !== 1'b1 ||
        axis.hcount_axis_tdata !== 11'd1) begin
      n_fail++;
      $display("FAIL split_issue got infl=%0d hv=%b hd=%0d exp 1 1 1",
               inflight, axis.hcount_axis_tvalid, axis.hcount_axis_tdata);
    end
  endtask

  task automatic test_abort();
    int s;
    do_reset();
    auto_en = 1;
    push_frame(3);
    do_start(s);
    step();
    step();
    axis.vcount_axis_tready = 1'b0;
    step();
    abort = 1'b1;
    n_chk++;
    if (axis.hcount_axis_tvalid !== 1'b0 || axis.vcount_axis_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pending got hv=%b%b exp 01",
               axis.hcount_axis_tvalid, axis.vcount_axis_tvalid);
    end
    step();
    abort = 1'b0;
    axis.vcount_axis_tready = 1'b1;
    wait_fd(60);
    n_chk++;
    if (!fd_ok) begin
      n_fail++;
      $display("FAIL abort_timeout got 0 exp 1");
    end
    repeat (4) step();
    n_chk++;
    if (niss !== 3 || nh !== 3 || nv !== 3) begin
      n_fail++;
      $display("FAIL abort_count got n=%0d h=%0d v=%0d exp 3 3 3",
               niss, nh, nv);
    end
    n_chk++;
    if (n_fd !== 1 || fd_cyc !== last_rd + 1 || busy !== 1'b0 ||
        inflight !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_drain got n=%0d c=%0d busy=%b infl=%0d exp 1 %0d 0 0",
               n_fd, fd_cyc, busy, inflight, last_rd + 1);
    end
  endtask

  task automatic test_counter();
    int s;
    do_reset();
    push_frame(8);
    do_start(s);
    step();
    rd_man = 1'b1;
    step();
    rd_man = 1'b0;
    n_chk++;
    if (inflight !== 3'd1 || credit_err !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle got infl=%0d err=%b exp 1 0",
               inflight, credit_err);
    end
    do_reset();
    rd_man = 1'b1;
    step();
    rd_man = 1'b0;
    n_chk++;
    if (credit_err !== 1'b1 || inflight !== 3'd0) begin
      n_fail++;
      $display("FAIL credit_err_set got err=%b infl=%0d exp 1 0",
               credit_err, inflight);
    end
    step();
    n_chk++;
    if (credit_err !== 1'b1) begin
      n_fail++;
      $display("FAIL credit_err_sticky got %b exp 1", credit_err);
    end
    push_frame(8);
    do_start(s);
    n_chk++;
    if (credit_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL credit_err_clear got err=%b busy=%b exp 0 1",
               credit_err, busy);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    logic [29:0] o;
    do_reset();
    push_frame(8);
    do_start(s);
    step();
    n_chk++;
    if (axis.hcount_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_pre got hv=%b busy=%b exp 1 1",
               axis.hcount_axis_tvalid, busy);
    end
    #2;
    aresetn = 1'b0;
    #1;
    o = {busy, frame_done, inflight, credit_err,
         axis.hcount_axis_tvalid, axis.vcount_axis_tvalid,
         axis.hcount_axis_tdata, axis.vcount_axis_tdata};
    n_chk++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL async_reset got %h exp 0", o);
    end
    clear_sb();
    step();
    aresetn = 1'b1;
    step();
    push_frame(8);
    do_start(s);
    n_chk++;
    if (axis.hcount_axis_tvalid !== 1'b1 || axis.hcount_axis_tdata !== 11'd0 ||
        axis.vcount_axis_tdata !== 10'd0 || inflight !== 3'd0) begin
      n_fail++;
      $display("FAIL restart got hv=%b h=%0d v=%0d infl=%0d exp 1 0 0 0",
               axis.hcount_axis_tvalid, axis.hcount_axis_tdata,
               axis.vcount_axis_tdata, inflight);
    end
    step();
    n_chk++;
    if (inflight !== 3'd1 || axis.hcount_axis_tdata !== 11'd1) begin
      n_fail++;
      $display("FAIL restart_next got infl=%0d h=%0d exp 1 1",
               inflight, axis.hcount_axis_tdata);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_credit();
    test_split();
    test_abort();
    test_counter();
    test_back_to_back();
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
